// File: rtl/fetch_seq_ctrl_if.sv
// Fetch-sequencer handshake bundle: hazard/branch inputs, IM handshake and
// the PC / F-D register controls. master = sequencer, slave = surrounding datapath.
interface fetch_seq_ctrl_if;
  logic        stall_d;
  logic        br_taken;
  logic [31:0] br_target;
  logic        im_ack;
  logic        im_req;
  logic        pc_en;
  logic [1:0]  pc_src;
  logic [31:0] npc;
  logic        fd_en;
  logic        fd_clr;
  logic        busy;
  logic        err;

  modport master (
    input  stall_d, br_taken, br_target, im_ack,
    output im_req, pc_en, pc_src, npc, fd_en, fd_clr, busy, err
  );

  modport slave (
    output stall_d, br_taken, br_target, im_ack,
    input  im_req, pc_en, pc_src, npc, fd_en, fd_clr, busy, err
  );
endinterface

// File: rtl/fetch_seq_ctrl.sv
// Fetch-stage sequencer for a variable-latency instruction memory: drives PC
// load/select, gates and bubbles F/D, and parks redirects that land mid-fetch.
module fetch_seq_ctrl #(
  parameter int MAX_WAIT = 16,
  parameter int CNT_W    = 5
) (
  input logic              clk,
  input logic              reset,
  fetch_seq_ctrl_if.master bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    ERR   = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(MAX_WAIT - 1);
  localparam logic [1:0]       SRC_SEQ   = 2'b00;
  localparam logic [1:0]       SRC_NPC   = 2'b01;

  state_t           state, state_nxt;
  logic             redir_v;
  logic [31:0]      redir_q;
  logic [CNT_W-1:0] wait_cnt;

  logic        im_req, pc_en, fd_en, fd_clr, busy, err;
  logic [1:0]  pc_src;
  logic [31:0] npc;
  logic        capture;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:  state_nxt = FETCH;
      FETCH: begin
        if (bus.im_ack && bus.stall_d)          state_nxt = HOLD;
        else if (!bus.im_ack && wait_cnt == LAST_WAIT) state_nxt = ERR;
      end
      HOLD:  if (!bus.stall_d) state_nxt = FETCH;
      ERR:   state_nxt = ERR;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: every output gets a default before the case so no latch is inferred.
  always_comb begin
    im_req = 1'b0;
    pc_en  = 1'b0;
    fd_en  = 1'b0;
    fd_clr = 1'b0;
    busy   = 1'b0;
    err    = 1'b0;
    pc_src = SRC_SEQ;
    npc    = '0;
    unique case (state)
      FETCH: begin
        im_req = 1'b1;
        if (bus.im_ack) begin
          if (!bus.stall_d) begin
            pc_en = 1'b1;
            fd_en = 1'b1;
          end
        end else begin
          busy = 1'b1;
          // Latency bubble: D keeps moving but sees a NOP.
          if (!bus.stall_d) begin
            fd_en  = 1'b1;
            fd_clr = 1'b1;
          end
        end
      end
      HOLD: begin
        if (!bus.stall_d) begin
          pc_en = 1'b1;
          fd_en = 1'b1;
        end
      end
      ERR:     err = 1'b1;
      default: ;
    endcase
    // A live branch outranks a parked one: it is the newer redirect.
    if (pc_en) begin
      if (bus.br_taken) begin
        pc_src = SRC_NPC;
        npc    = bus.br_target;
      end else if (redir_v) begin
        pc_src = SRC_NPC;
        npc    = redir_q;
      end
    end
  end

  // Branch resolved while the IM is still busy: park it until the PC can load.
  assign capture = (state == FETCH) && !bus.im_ack && !bus.stall_d && bus.br_taken;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      redir_v  <= 1'b0;
      redir_q  <= '0;
      wait_cnt <= '0;
    end else begin
      if (pc_en) begin
        redir_v <= 1'b0;
      end else if (capture) begin
        redir_v <= 1'b1;
        redir_q <= bus.br_target;
      end
      if (state == FETCH)
        wait_cnt <= bus.im_ack ? '0 : wait_cnt + CNT_W'(1);
    end
  end

  assign bus.im_req = im_req;
  assign bus.pc_en  = pc_en;
  assign bus.pc_src = pc_src;
  assign bus.npc    = npc;
  assign bus.fd_en  = fd_en;
  assign bus.fd_clr = fd_clr;
  assign bus.busy   = busy;
  assign bus.err    = err;

endmodule

// File: tb/tb_fetch_seq_ctrl.sv
// Directed bench for fetch_seq_ctrl (MAX_WAIT=4): each scenario task applies a
// table of per-cycle inputs and compares outputs against hand-computed values.
module tb_fetch_seq_ctrl;

  logic clk;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  fetch_seq_ctrl_if bus ();

  fetch_seq_ctrl #(.MAX_WAIT(4), .CNT_W(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Output flag vector: {im_req, pc_en, pc_src[1:0], fd_en, fd_clr, busy, err}
  localparam logic [7:0] F_OFF  = 8'h00; // IDLE, HOLD-stalled, in reset
  localparam logic [7:0] F_ADV  = 8'hC8; // FETCH ack, PC+4
  localparam logic [7:0] F_ADVR = 8'hD8; // FETCH ack, redirect
  localparam logic [7:0] F_BUB  = 8'h8E; // waiting, bubble into D
  localparam logic [7:0] F_WSTL = 8'h82; // waiting, D stalled
  localparam logic [7:0] F_ASTL = 8'h80; // ack while D stalled
  localparam logic [7:0] F_REL  = 8'h48; // HOLD release, PC+4
  localparam logic [7:0] F_RELR = 8'h58; // HOLD release, redirect
  localparam logic [7:0] F_ERR  = 8'h01;

  typedef struct {
    logic        rst_n;
    logic        stall;
    logic        br;
    logic        ack;
    logic [31:0] tgt;
    logic [7:0]  e_flags;
    logic [31:0] e_npc;
    logic        e_rv;
  } vec_t;

  function automatic vec_t mk(logic rst_n, logic stall, logic br, logic ack,
                              logic [31:0] tgt, logic [7:0] e_flags,
                              logic [31:0] e_npc, logic e_rv);
    vec_t v;
    v.rst_n = rst_n; v.stall = stall; v.br = br; v.ack = ack; v.tgt = tgt;
    v.e_flags = e_flags; v.e_npc = e_npc; v.e_rv = e_rv;
    return v;
  endfunction

  function automatic logic [7:0] flags();
    return {bus.im_req, bus.pc_en, bus.pc_src, bus.fd_en, bus.fd_clr, bus.busy, bus.err};
  endfunction

  task automatic apply(input vec_t v);
    reset         = v.rst_n;
    bus.stall_d   = v.stall;
    bus.br_taken  = v.br;
    bus.im_ack    = v.ack;
    bus.br_target = v.tgt;
    #2;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    vec_t v[$];
    for (int i = 0; i < 3; i++) v.push_back(mk(0, 0, 0, 1, 0, F_OFF, 0, 0));
    v.push_back(mk(1, 0, 0, 1, 0, F_OFF, 0, 0));  // IDLE after release
    for (int i = 0; i < v.size(); i++) begin
      apply(v[i]);
      checks++;
      if ({flags(), bus.npc, dut.redir_v} !== {v[i].e_flags, v[i].e_npc, v[i].e_rv}) begin
        errors++;
        $display("FAIL reset[%0d] got flags=%b npc=%h rv=%b want flags=%b npc=%h rv=%b",
                 i, flags(), bus.npc, dut.redir_v, v[i].e_flags, v[i].e_npc, v[i].e_rv);
      end
      next_cycle();
    end
  endtask

  task automatic test_stream();
    vec_t v[$];
    for (int i = 0; i < 4; i++) v.push_back(mk(1, 0, 0, 1, 0, F_ADV, 0, 0));
    for (int i = 0; i < v.size(); i++) begin
      apply(v[i]);
      checks++;
      if ({flags(), bus.npc, dut.redir_v} !== {v[i].e_flags, v[i].e_npc, v[i].e_rv}) begin
        errors++;
        $display("FAIL stream[%0d] got flags=%b npc=%h rv=%b want flags=%b npc=%h rv=%b",
                 i, flags(), bus.npc, dut.redir_v, v[i].e_flags, v[i].e_npc, v[i].e_rv);
      end
      next_cycle();
    end
  endtask

  task automatic test_latency();
    vec_t v[$];
    for (int i = 0; i < 3; i++) v.push_back(mk(1, 0, 0, 0, 0, F_BUB, 0, 0));
    v.push_back(mk(1, 0, 0, 1, 0, F_ADV, 0, 0));  // 4th wait cycle acks: no timeout
    v.push_back(mk(1, 0, 0, 1, 0, F_ADV, 0, 0));
    for (int i = 0; i < v.size(); i++) begin
      apply(v[i]);
      checks++;
      if ({flags(), bus.npc, dut.redir_v} !== {v[i].e_flags, v[i].e_npc, v[i].e_rv}) begin
        errors++;
        $display("FAIL latency[%0d] got flags=%b npc=%h rv=%b want flags=%b npc=%h rv=%b",
                 i, flags(), bus.npc, dut.redir_v, v[i].e_flags, v[i].e_npc, v[i].e_rv);
      end
      next_cycle();
    end
  endtask

  task automatic test_redirect();
    vec_t v[$];
    v.push_back(mk(1, 0, 1, 0, 32'h1000, F_BUB,  0, 0));        // captured
    v.push_back(mk(1, 1, 1, 0, 32'hDEAD, F_WSTL, 0, 1));        // stalled: ignored
    v.push_back(mk(1, 0, 1, 0, 32'h3040, F_BUB,  0, 1));        // newest wins
    v.push_back(mk(1, 0, 0, 1, 0,        F_ADVR, 32'h3040, 1)); // consumed on ack
    v.push_back(mk(1, 0, 0, 1, 0,        F_ADV,  0, 0));
    v.push_back(mk(1, 0, 1, 1, 32'h2000, F_ADVR, 32'h2000, 0)); // direct redirect
    v.push_back(mk(1, 0, 0, 1, 0,        F_ADV,  0, 0));
    for (int i = 0; i < v.size(); i++) begin
      apply(v[i]);
      checks++;
      if ({flags(), bus.npc, dut.redir_v} !== {v[i].e_flags, v[i].e_npc, v[i].e_rv}) begin
        errors++;
        $display("FAIL redirect[%0d] got flags=%b npc=%h rv=%b want flags=%b npc=%h rv=%b",
                 i, flags(), bus.npc, dut.redir_v, v[i].e_flags, v[i].e_npc, v[i].e_rv);
      end
      next_cycle();
    end
  endtask

  task automatic test_hold();
    vec_t v[$];
    v.push_back(mk(1, 1, 0, 1, 0,        F_ASTL, 0, 0));        // ack under stall -> HOLD
    v.push_back(mk(1, 1, 0, 0, 0,        F_OFF,  0, 0));
    v.push_back(mk(1, 1, 0, 0, 0,        F_OFF,  0, 0));
    v.push_back(mk(1, 0, 0, 0, 0,        F_REL,  0, 0));        // release -> FETCH
    v.push_back(mk(1, 0, 0, 1, 0,        F_ADV,  0, 0));
    v.push_back(mk(1, 1, 0, 1, 0,        F_ASTL, 0, 0));
    v.push_back(mk(1, 0, 1, 0, 32'h5000, F_RELR, 32'h5000, 0)); // release with branch
    v.push_back(mk(1, 0, 0, 1, 0,        F_ADV,  0, 0));
    for (int i = 0; i < v.size(); i++) begin
      apply(v[i]);
      checks++;
      if ({flags(), bus.npc, dut.redir_v} !== {v[i].e_flags, v[i].e_npc, v[i].e_rv}) begin
        errors++;
        $display("FAIL hold[%0d] got flags=%b npc=%h rv=%b want flags=%b npc=%h rv=%b",
                 i, flags(), bus.npc, dut.redir_v, v[i].e_flags, v[i].e_npc, v[i].e_rv);
      end
      next_cycle();
    end
  endtask

  task automatic test_reset_mid_fetch();
    vec_t v[$];
    v.push_back(mk(1, 0, 1, 0, 32'h4444, F_BUB, 0, 0));
    v.push_back(mk(1, 0, 0, 0, 0,        F_BUB, 0, 1));
    v.push_back(mk(0, 0, 0, 1, 0,        F_OFF, 0, 0)); // async reset mid-cycle
    v.push_back(mk(1, 0, 0, 1, 0,        F_OFF, 0, 0)); // IDLE
    v.push_back(mk(1, 0, 0, 1, 0,        F_ADV, 0, 0)); // redirect discarded
    for (int i = 0; i < v.size(); i++) begin
      apply(v[i]);
      checks++;
      if ({flags(), bus.npc, dut.redir_v} !== {v[i].e_flags, v[i].e_npc, v[i].e_rv}) begin
        errors++;
        $display("FAIL reset_mid[%0d] got flags=%b npc=%h rv=%b want flags=%b npc=%h rv=%b",
                 i, flags(), bus.npc, dut.redir_v, v[i].e_flags, v[i].e_npc, v[i].e_rv);
      end
      next_cycle();
    end
  endtask

  task automatic test_timeout();
    vec_t v[$];
    for (int i = 0; i < 4; i++) v.push_back(mk(1, 0, 0, 0, 0, F_BUB, 0, 0));
    v.push_back(mk(1, 0, 0, 0, 0,        F_ERR, 0, 0));  // 5th cycle: ERR
    v.push_back(mk(1, 0, 0, 1, 0,        F_ERR, 0, 0));  // sticky despite ack
    v.push_back(mk(1, 0, 1, 1, 32'h7000, F_ERR, 0, 0));
    v.push_back(mk(0, 0, 0, 1, 0,        F_OFF, 0, 0));
    v.push_back(mk(1, 0, 0, 1, 0,        F_OFF, 0, 0));
    v.push_back(mk(1, 0, 0, 1, 0,        F_ADV, 0, 0));
    for (int i = 0; i < v.size(); i++) begin
      apply(v[i]);
      checks++;
      if ({flags(), bus.npc, dut.redir_v} !== {v[i].e_flags, v[i].e_npc, v[i].e_rv}) begin
        errors++;
        $display("FAIL timeout[%0d] got flags=%b npc=%h rv=%b want flags=%b npc=%h rv=%b",
                 i, flags(), bus.npc, dut.redir_v, v[i].e_flags, v[i].e_npc, v[i].e_rv);
      end
      next_cycle();
    end
  endtask

  initial begin
    reset         = 1'b0;
    bus.stall_d   = 1'b0;
    bus.br_taken  = 1'b0;
    bus.br_target = '0;
    bus.im_ack    = 1'b0;
    @(posedge clk);
    #1;
    test_reset();
    test_stream();
    test_latency();
    test_redirect();
    test_hold();
    test_reset_mid_fetch();
    test_timeout();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
